// File: rtl/comp_arb.sv
// comp_arb: one shared unsigned W-bit comparator, time-multiplexed among
// N_REQ requesters with round-robin arbitration. Each transaction captures
// the winner's operands, produces a registered gr/ls/eq result tagged with
// the requester index, and holds it until the consumer accepts it.
module comp_arb #(
    parameter int N_REQ = 4,
    parameter int W     = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] a_in,
    input  logic [N_REQ*W-1:0] b_in,
    output logic [N_REQ-1:0]   gnt,
    output logic               busy,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [1:0]         res_id,
    output logic               gr,
    output logic               ls,
    output logic               eq
);

    typedef enum logic [1:0] {
        IDLE,
        CMP,
        RESP
    } state_t;

    state_t         state;
    logic [1:0]     last_winner;
    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;

    logic           win_found;
    logic [1:0]     win_idx;
    logic [1:0]     cand;
    logic [W-1:0]   a_sel;
    logic [W-1:0]   b_sel;

    // Round-robin search starting one past the last winner; 2-bit index wraps 3->0.
    always_comb begin
        win_found = 1'b0;
        win_idx   = last_winner;
        cand      = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = last_winner + 2'(k + 1);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
        a_sel = a_in[W*win_idx +: W];
        b_sel = b_in[W*win_idx +: W];
    end

    // Control FSM with registered outputs: capture in IDLE, compare in CMP, hold in RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last_winner <= 2'd3;
            op_a        <= '0;
            op_b        <= '0;
            gnt         <= '0;
            busy        <= 1'b0;
            res_valid   <= 1'b0;
            res_id      <= '0;
            gr          <= 1'b0;
            ls          <= 1'b0;
            eq          <= 1'b0;
        end else begin
            gnt <= '0;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        op_a         <= a_sel;
                        op_b         <= b_sel;
                        last_winner  <= win_idx;
                        gnt[win_idx] <= 1'b1;
                        busy         <= 1'b1;
                        state        <= CMP;
                    end
                end
                CMP: begin
                    // last_winner only moves on capture, so it still names the owner here
                    gr        <= (op_a > op_b);
                    ls        <= (op_a < op_b);
                    eq        <= (op_a == op_b);
                    res_id    <= last_winner;
                    res_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/comp_arb.md
COMP_ARB -- requirements
Module: comp_arb

Interface
REQ-001 Parameter: N_REQ, 4, number of requesters sharing the comparator (fixed at 4 in this revision).
REQ-002 Parameter: W, 4, operand width in bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req  input  4  per-requester request, level; bit i = requester i.
REQ-006 a_in  input  16  packed operand A; bits [4i+3:4i] belong to requester i.
REQ-007 b_in  input  16  packed operand B; same packing as a_in.
REQ-008 gnt  output  4  one-hot grant pulse, registered; operands of that requester captured.
REQ-009 busy  output  1  high whenever FSM is not IDLE.
REQ-010 res_valid  output  1  result available.
REQ-011 res_ready  input  1  consumer accepts result when high with res_valid.
REQ-012 res_id  output  2  index of requester owning the result.
REQ-013 gr, ls, eq  output  1 each  unsigned compare of captured A vs B: A>B, A<B, A==B.

Function
REQ-014 FSM states SHALL be IDLE, CMP, RESP; encoding free.
REQ-015 IDLE: if req != 0, SHALL select winner, capture its a/b into internal operand registers, assert gnt[winner] for exactly the next cycle, go to CMP; if req == 0, stay IDLE, gnt = 0.
REQ-016 Arbitration SHALL be round-robin: search starts at (last_winner+1) mod 4, wraps 3->0; last_winner updated only on capture.
REQ-017 CMP: SHALL compute gr/ls/eq from captured operands, register them with res_id, set res_valid, go to RESP; exactly one of gr/ls/eq high.
REQ-018 RESP: res_valid, res_id, gr, ls, eq SHALL hold stable until res_valid && res_ready; on that edge clear res_valid, go to IDLE.
REQ-019 Latency: capture edge E0, result registered at E1 (res_valid high after E1); with res_ready held high, next capture possible at E3 (one compare per 3 cycles).
REQ-020 req and a_in/b_in changes during CMP/RESP SHALL NOT affect the in-flight result; no capture outside IDLE.
REQ-021 A requester still holding req after its gnt SHALL be re-arbitrated normally (lowest priority next round); the block does not require req to drop.
REQ-022 gnt SHALL be zero in all cycles except the single cycle after a capture edge; never more than one bit set.
REQ-023 Compare SHALL be unsigned, W bits, no sign extension.

Reset
REQ-024 On rst_n low, asynchronously: state=IDLE, gnt=0, busy=0, res_valid=0, res_id=0, gr=ls=eq=0, operand regs=0, last_winner=3 (so requester 0 has first priority).
REQ-025 Reset asserted mid-operation (CMP or RESP) SHALL abort the in-flight compare; no result is delivered after release.
REQ-026 After rst_n deasserts, first capture SHALL occur on the first rising edge with req != 0.

Verification
REQ-027 Single request: req=0001, a0=0, b0=1, res_ready=1 -> gnt=0001 one cycle, res_valid one cycle later with res_id=0, ls=1, gr=0, eq=0.
REQ-028 All requesting, all held: req=1111, a_i=4'hE, b_i=4'h1 -> gnt sequence 0001,0010,0100,1000,0001; each result gr=1 with matching res_id.
REQ-029 Back-pressure: a=3, b=3, res_ready=0 for 5 cycles -> res_valid, eq=1, res_id stable for all 5 cycles, busy=1, no gnt; res_ready=1 -> accepted, IDLE next cycle.
REQ-030 Operand change after grant: capture a=4'hF, b=4'h0 then drive a=0 in CMP -> gr=1 reported.
REQ-031 Reset mid-RESP: rst_n low while res_valid=1 -> all outputs 0 immediately; after release with req=0, res_valid stays 0.
REQ-032 Wrap boundary: last winner=3, req=1001 -> requester 0 granted, then requester 3.
